// File: rtl/systolic_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : systolic_feeder_pkg
//  Brief   : Shared sizes, phase lengths, state encoding and buffer types.
//  Revision: 1.0
// ============================================================================
package systolic_feeder_pkg;

    localparam int N     = 32;
    localparam int D     = 5;
    localparam int M     = D * D;
    localparam int CNT_W = 4;

    localparam int COMPUTE_LEN  = 3 * D - 2;
    localparam int DRAIN_RW_LEN = 2 * D - 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        COMPUTE  = 3'd2,
        DRAIN_W  = 3'd3,
        DRAIN_RW = 3'd4,
        FINISH   = 3'd5
    } state_t;

    typedef logic [N-1:0]   elem_t;
    typedef elem_t [D-1:0]  row_t;
    typedef row_t  [D-1:0]  mat_t;

endpackage
`default_nettype wire

// File: rtl/systolic_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module  : systolic_feeder_if
//  Brief   : Host-side load bus and job handshake of the systolic feeder.
//  Revision: 1.0
// ============================================================================
interface systolic_feeder_if;
    import systolic_feeder_pkg::*;

    logic           ld_en;
    logic           ld_sel;
    logic [2:0]     ld_row;
    logic [D*N-1:0] ld_data;
    logic           start;
    logic           busy;
    logic           done;

    modport master (
        output ld_en, ld_sel, ld_row, ld_data, start,
        input  busy, done
    );

    modport slave (
        input  ld_en, ld_sel, ld_row, ld_data, start,
        output busy, done
    );

endinterface
`default_nettype wire

// File: rtl/systolic_feeder_skew_mux.sv
`default_nettype none
// ============================================================================
//  Module  : systolic_feeder_skew_mux
//  Brief   : Picks the diagonally skewed operand of one lane at step t.
//  Revision: 1.0
// ============================================================================
module systolic_feeder_skew_mux
    import systolic_feeder_pkg::*;
#(
    parameter bit COL = 1'b0
) (
    input  mat_t             mat_i,
    input  logic [2:0]       lane_i,
    input  logic [CNT_W-1:0] t_i,
    output elem_t            op_o
);

    // Negative t - lane wraps to a large value and falls outside the window.
    logic [CNT_W:0] w_k;
    assign w_k = {1'b0, t_i} - {2'b00, lane_i};

    always_comb begin
        op_o = '0;
        if (w_k < (CNT_W+1)'(D)) begin
            op_o = COL ? mat_i[w_k[2:0]][lane_i] : mat_i[lane_i][w_k[2:0]];
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module  : systolic_feeder
//  Brief   : Buffers A/B, streams skewed operands and drains a 5x5 array.
//  Revision: 1.0
// ============================================================================
module systolic_feeder
    import systolic_feeder_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    systolic_feeder_if.slave host,
    output logic [N-1:0]    A0,
    output logic [N-1:0]    A1,
    output logic [N-1:0]    A2,
    output logic [N-1:0]    A3,
    output logic [N-1:0]    A4,
    output logic [N-1:0]    B0,
    output logic [N-1:0]    B1,
    output logic [N-1:0]    B2,
    output logic [N-1:0]    B3,
    output logic [N-1:0]    B4,
    output logic [M-1:0]    pe_clr,
    output logic [M-1:0]    pe_read,
    output logic [M-1:0]    pe_write,
    output logic            res_valid,
    output logic [2:0]      res_row
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    mat_t  a_buf_q, b_buf_q;
    logic  rst_hold_q;

    elem_t a_op [D];
    elem_t b_op [D];
    elem_t a_q  [D];
    elem_t b_q  [D];

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        clr_q, clr_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        rv_q, rv_d;
    logic [2:0]  row_q, row_d;
    logic        op_en_d;

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (host.start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                state_d = COMPUTE;
                cnt_d   = '0;
            end
            COMPUTE: begin
                if (cnt_q == CNT_W'(COMPUTE_LEN - 1)) begin
                    state_d = DRAIN_W;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN_W: begin
                state_d = DRAIN_RW;
                cnt_d   = '0;
            end
            DRAIN_RW: begin
                if (cnt_q == CNT_W'(DRAIN_RW_LEN - 1)) begin
                    state_d = FINISH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FINISH);
        clr_d   = (state_d == CLEAR);
        wr_d    = (state_d == DRAIN_W) || (state_d == DRAIN_RW);
        rd_d    = (state_d == DRAIN_RW);
        op_en_d = (state_d == COMPUTE);
        rv_d    = 1'b0;
        row_d   = '0;
        // Each result row surfaces every second drain cycle, bottom row first.
        if (state_d == DRAIN_RW && !cnt_d[0]) begin
            rv_d  = 1'b1;
            row_d = 3'd4 - cnt_d[3:1];
        end else if (state_d == FINISH) begin
            rv_d  = 1'b1;
            row_d = '0;
        end
    end

    for (genvar g = 0; g < D; g++) begin : g_lane
        systolic_feeder_skew_mux #(.COL(1'b0)) u_a_mux (
            .mat_i  (a_buf_q),
            .lane_i (3'(g)),
            .t_i    (cnt_d),
            .op_o   (a_op[g])
        );
        systolic_feeder_skew_mux #(.COL(1'b1)) u_b_mux (
            .mat_i  (b_buf_q),
            .lane_i (3'(g)),
            .t_i    (cnt_d),
            .op_o   (b_op[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rv_q    <= 1'b0;
            row_q   <= '0;
            for (int i = 0; i < D; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clr_q   <= clr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rv_q    <= rv_d;
            row_q   <= row_d;
            for (int i = 0; i < D; i++) begin
                a_q[i] <= op_en_d ? a_op[i] : '0;
                b_q[i] <= op_en_d ? b_op[i] : '0;
            end
        end
    end

    // A single reset cycle only aborts the job; buffers clear once reset is held.
    always_ff @(posedge clk) begin
        rst_hold_q <= !rst_n;
        if (!rst_n) begin
            if (rst_hold_q) begin
                a_buf_q <= '0;
                b_buf_q <= '0;
            end
        end else if (host.ld_en && !busy_q && (host.ld_row < 3'(D))) begin
            if (host.ld_sel) begin
                b_buf_q[host.ld_row] <= host.ld_data;
            end else begin
                a_buf_q[host.ld_row] <= host.ld_data;
            end
        end
    end

    assign host.busy = busy_q;
    assign host.done = done_q;

    assign A0 = a_q[0];
    assign A1 = a_q[1];
    assign A2 = a_q[2];
    assign A3 = a_q[3];
    assign A4 = a_q[4];
    assign B0 = b_q[0];
    assign B1 = b_q[1];
    assign B2 = b_q[2];
    assign B3 = b_q[3];
    assign B4 = b_q[4];

    assign pe_clr    = {M{clr_q}};
    assign pe_read   = {M{rd_q}};
    assign pe_write  = {M{wr_q}};
    assign res_valid = rv_q;
    assign res_row   = row_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_systolic_feeder
//  Brief   : Directed bench with a behavioural output-stationary array model.
//  Revision: 1.0
// ============================================================================
module tb_systolic_feeder;
    import systolic_feeder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    systolic_feeder_if host_if ();

    logic [N-1:0] tA [5];
    logic [N-1:0] tB [5];
    logic [M-1:0] pe_clr, pe_read, pe_write;
    logic         res_valid;
    logic [2:0]   res_row;

    systolic_feeder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (host_if),
        .A0        (tA[0]),
        .A1        (tA[1]),
        .A2        (tA[2]),
        .A3        (tA[3]),
        .A4        (tA[4]),
        .B0        (tB[0]),
        .B1        (tB[1]),
        .B2        (tB[2]),
        .B3        (tB[3]),
        .B4        (tB[4]),
        .pe_clr    (pe_clr),
        .pe_read   (pe_read),
        .pe_write  (pe_write),
        .res_valid (res_valid),
        .res_row   (res_row)
    );

    // Array model: A flows right, B flows down, each PE accumulates a*b.
    logic [N-1:0] pa  [5][5];
    logic [N-1:0] pb  [5][5];
    logic [N-1:0] acc [5][5];
    logic [N-1:0] ai_m, bi_m;

    initial begin
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                pa[i][j]  = '0;
                pb[i][j]  = '0;
                acc[i][j] = '0;
            end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                if (j == 0) ai_m = tA[i];
                else        ai_m = pa[i][j-1];
                if (i == 0) bi_m = tB[j];
                else        bi_m = pb[i-1][j];
                pa[i][j]  <= ai_m;
                pb[i][j]  <= bi_m;
                acc[i][j] <= pe_clr[5*i+j] ? '0 : acc[i][j] + ai_m * bi_m;
            end
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    logic [N-1:0] Am [5][5];
    logic [N-1:0] Bm [5][5];
    logic [N-1:0] Cexp [5][5];
    logic [N-1:0] sA2 [5];
    logic [N-1:0] sB2 [5];
    logic [N-1:0] sA6 [5];
    logic [N-1:0] sB6 [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [N-1:0] lanes_or();
        logic [N-1:0] v = '0;
        for (int i = 0; i < 5; i++) v = v | tA[i] | tB[i];
        return v;
    endfunction

    task automatic calc_c();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                Cexp[r][c] = '0;
                for (int k = 0; k < 5; k++) Cexp[r][c] = Cexp[r][c] + Am[r][k] * Bm[k][c];
            end
    endtask

    task automatic drive_row(input bit sel, input int r);
        host_if.ld_en  = 1'b1;
        host_if.ld_sel = sel;
        host_if.ld_row = 3'(r);
        for (int k = 0; k < 5; k++)
            host_if.ld_data[N*k +: N] = sel ? Bm[r][k] : Am[r][k];
    endtask

    task automatic load_all(input bit skip_last_b);
        for (int r = 0; r < 5; r++) begin
            drive_row(1'b0, r);
            tick();
        end
        for (int r = 0; r < 5; r++) begin
            if (!(skip_last_b && r == 4)) begin
                drive_row(1'b1, r);
                tick();
            end
        end
        host_if.ld_en = 1'b0;
    endtask

    // Entered in an idle cycle, which becomes cycle 0 of the job.
    task automatic run_job(input int inj_start, input int inj_ld, input int abort_at,
                           input bit load_with_start);
        bit exp_busy, exp_done, exp_rv;
        int rr;
        bit seen_done;
        host_if.start = 1'b1;
        if (load_with_start) drive_row(1'b1, 4);
        tick();
        host_if.start = 1'b0;
        host_if.ld_en = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (c == abort_at) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                chk("abort_busy",  host_if.busy, 0);
                chk("abort_done",  host_if.done, 0);
                chk("abort_rv",    {res_valid, res_row}, 0);
                chk("abort_lanes", lanes_or(), 0);
                chk("abort_pe",    pe_clr | pe_read | pe_write, 0);
                seen_done = 1'b0;
                repeat (16) begin
                    tick();
                    seen_done = seen_done | host_if.done;
                end
                chk("abort_nodone", seen_done, 0);
                return;
            end
            exp_busy = (c <= 24);
            exp_done = (c == 24);
            exp_rv   = (c >= 16) && (c <= 24) && (c % 2 == 0);
            rr       = exp_rv ? (24 - c) / 2 : 0;
            chk($sformatf("busy@%0d", c), host_if.busy, exp_busy);
            chk($sformatf("done@%0d", c), host_if.done, exp_done);
            chk($sformatf("res@%0d", c), {res_valid, res_row}, {exp_rv, 3'(rr)});
            chk($sformatf("clr@%0d", c), pe_clr, (c == 1) ? {M{1'b1}} : {M{1'b0}});
            chk($sformatf("wr@%0d", c), pe_write, (c >= 15 && c <= 23) ? {M{1'b1}} : {M{1'b0}});
            chk($sformatf("rd@%0d", c), pe_read, (c >= 16 && c <= 23) ? {M{1'b1}} : {M{1'b0}});
            if (c < 2 || c > 14) chk($sformatf("lanes0@%0d", c), lanes_or(), 0);
            if (exp_rv)
                for (int j = 0; j < 5; j++)
                    chk($sformatf("C[%0d][%0d]@%0d", rr, j, c), acc[rr][j], Cexp[rr][j]);
            for (int i = 0; i < 5; i++) begin
                if (c == 2) begin sA2[i] = tA[i]; sB2[i] = tB[i]; end
                if (c == 6) begin sA6[i] = tA[i]; sB6[i] = tB[i]; end
            end
            if (c == inj_start) host_if.start = 1'b1;
            if (c == inj_ld) begin
                host_if.ld_en   = 1'b1;
                host_if.ld_sel  = 1'b0;
                host_if.ld_row  = 3'd0;
                host_if.ld_data = '1;
            end
            tick();
            host_if.start = 1'b0;
            host_if.ld_en = 1'b0;
        end
    endtask

    initial begin
        host_if.ld_en   = 1'b0;
        host_if.ld_sel  = 1'b0;
        host_if.ld_row  = '0;
        host_if.ld_data = '0;
        host_if.start   = 1'b0;

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_busy",  host_if.busy, 0);
        chk("rst_done",  host_if.done, 0);
        chk("rst_res",   {res_valid, res_row}, 0);
        chk("rst_lanes", lanes_or(), 0);
        chk("rst_pe",    pe_clr | pe_read | pe_write, 0);

        // Identity A, B[r][c] = 10r+c; last B row loaded together with start.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                Am[r][c] = (r == c) ? 1 : 0;
                Bm[r][c] = 10 * r + c;
            end
        calc_c();
        load_all(1'b1);
        host_if.ld_en   = 1'b1;
        host_if.ld_sel  = 1'b1;
        host_if.ld_row  = 3'd5;
        host_if.ld_data = '1;
        tick();
        host_if.ld_en = 1'b0;
        run_job(0, 0, 0, 1'b1);
        chk("id_C40", acc[4][0], 40);
        chk("id_C44", acc[4][4], 44);
        chk("id_C03", acc[0][3], 3);

        // All twos, with a stray start and load during the job.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                Am[r][c] = 2;
                Bm[r][c] = 2;
            end
        calc_c();
        load_all(1'b0);
        run_job(5, 8, 0, 1'b0);
        chk("two_C23", acc[2][3], 20);
        chk("t0_A0", sA2[0], 2);
        chk("t0_B0", sB2[0], 2);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("t0_A%0d", i), sA2[i], 0);
            chk($sformatf("t0_B%0d", i), sB2[i], 0);
        end
        run_job(0, 0, 0, 1'b0);

        // A[i][k] = 16i+k, B[r][c] = r+c: skew window at t=4.
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                Am[r][c] = 16 * r + c;
                Bm[r][c] = r + c;
            end
        calc_c();
        load_all(1'b0);
        run_job(0, 0, 0, 1'b0);
        chk("t4_A0", sA6[0], 32'h04);
        chk("t4_A1", sA6[1], 32'h13);
        chk("t4_A2", sA6[2], 32'h22);
        chk("t4_A3", sA6[3], 32'h31);
        chk("t4_A4", sA6[4], 32'h40);
        for (int j = 0; j < 5; j++) chk($sformatf("t4_B%0d", j), sB6[j], 4);

        // Single-cycle reset mid-job, then a clean job on the kept buffers.
        run_job(0, 0, 10, 1'b0);
        run_job(0, 0, 0, 1'b0);

        // Held reset zeroes both buffers.
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                Am[r][c] = '0;
                Bm[r][c] = '0;
            end
        calc_c();
        run_job(0, 0, 0, 1'b0);
        chk("hold_C11", acc[1][1], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream sequencer for the 5x5 output-stationary systolic array (32-bit PEs, 25-bit per-PE clr/read/write vectors).
- Holds one 5x5 A matrix and one 5x5 B matrix, loaded a row at a time.
- On start it clears the array, streams A rows and B columns with diagonal skew, then drives the drain sequence.
- It flags the cycles in which the array's B0_out..B4_out carry result row r of C = A x B.

Parameters:
N, 32, data width of every matrix element and array lane
D, 5, array dimension; fixed at 5 in this revision
M, 25, per-PE control vector width (D*D); bit index = 5*row + col

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
ld_en  input  1  write one matrix row into the buffer this cycle
ld_sel  input  1  0 = A buffer, 1 = B buffer
ld_row  input  3  row index 0..4; values 5..7 ignored
ld_data  input  5*N  row elements; element k in bits [N*k+N-1:N*k]
start  input  1  begin one multiply; ignored while busy
busy  output  1  high from the cycle after start until done, inclusive
done  output  1  one-cycle pulse, last cycle of a job
A0..A4  output  N each  row feeds into array layers 0..4
B0..B4  output  N each  column feeds into layer 0
pe_clr, pe_read, pe_write  output  M each  per-PE control to the array
res_valid  output  1  array B*_out currently holds a result row
res_row  output  3  index of that row; 0 when res_valid low

Behaviour:
- All outputs are registered. Reset state: IDLE, every output 0, both buffers zeroed.
- Reset low mid-job aborts at the next edge: IDLE, outputs 0, no done. Buffers keep their contents unless reset is held; the array clears on the next job.
- Loads:
  - Accepted only when busy=0. ld_en while busy is dropped silently.
  - Load and start in the same cycle: the load lands first, and the job uses the new row.
- Cycle numbering: start sampled high at the edge ending cycle 0. Cycle k is the k-th cycle after it.
- FSM states and their outputs:
  - IDLE: all controls 0, A*/B* 0. The array computes on zero operands, so accumulators hold.
  - CLEAR, cycle 1: pe_clr all ones; read and write 0.
  - COMPUTE, cycles 2..14 (t = cycle-2 = 0..12): controls 0.
    - Ai = A[i][t-i] if 0 <= t-i <= 4, else 0.
    - Bj = B[t-j][j] if 0 <= t-j <= 4, else 0.
    - PE(i,j) meets A[i][k] and B[k][j] at the same edge.
  - DRAIN_W, cycle 15: pe_write all ones; A*/B* 0.
  - DRAIN_RW, cycles 16..23: pe_read and pe_write all ones; B* must be 0, which fills row 0 with zeros.
  - FINISH, cycle 24: controls 0; done=1. Back to IDLE at cycle 25.
- busy is high in cycles 1..24.
- res_valid is high in cycles 16, 18, 20, 22 and 24, with res_row = 4, 3, 2, 1, 0 respectively. Each result row is presented once on the array's B*_out.
- Arithmetic:
  - Products and sums wrap modulo 2^N inside the array; the feeder does no arithmetic.
  - Skew indices come from a 4-bit step counter; out-of-window operands are forced to 0.
- start during busy: ignored, with no queueing.
- start held high: a new job begins at cycle 25, the first IDLE cycle.

Decomposition:
- Shared package holds:
  - D, N, M;
  - state encoding IDLE/CLEAR/COMPUTE/DRAIN_W/DRAIN_RW/FINISH;
  - phase lengths COMPUTE_LEN=13 (3*D-2) and DRAIN_RW_LEN=8 (2*D-2).
- One natural sub-module, skew_mux: combinational. Given matrix buffer, lane index and t, it returns the lane operand or 0. It is instantiated for A-row and B-column selection, and its outputs are registered in the top.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> busy, done, res_valid, all A*/B* and the pe_* vectors read 0.
- Identity test: load A = identity and B[r][c] = 10*r + c, start, feeder driving a real array -> res_row 4..0 rows read B rows: row 4 = 40, 41, 42, 43, 44 at cycle 16; row 0 = 0, 1, 2, 3, 4 at cycle 24. done pulses at cycle 24.
- All elements 2 in A and B -> every C element = 20 (5*2*2) on all five res_valid cycles.
- Skew check, COMPUTE t=4 with A[i][k] = 16*i + k -> A0=4, A1=0x13, A2=0x22, A3=0x31, A4=0x40.
- Skew check, t=0 -> only A0 and B0 are nonzero.
- start pulse at cycle 5 and ld_en at cycle 8 of a running job -> ignored: job ends at cycle 24 and the buffer is unchanged.
- Reset at cycle 10 -> outputs 0 next cycle, no done. A new start then gives a correct result, with CLEAR wiping the partial sums.
